algo_1r1w_a24_req_sched: RTL and testbench

- Host-side request scheduler sitting directly upstream of the 1r1w a24 algorithmic memory core.
- Buffers host write/read commands in an in-order FIFO and issues them to the core's write/read/refr inputs.
- Generates the periodic DRAM refresh slot (refr) and holds commands off during refresh and while the core is not ready.

---
 rtl/algo_1r1w_a24_req_sched.sv | 120 ++++++++++++
 tb/tb_algo_1r1w_a24_req_sched.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/algo_1r1w_a24_req_sched.sv
// Host-side request scheduler for the 1r1w a24 core: in-order command FIFO,
// periodic refresh-slot insertion, and issue gating on core ready.
module algo_1r1w_a24_req_sched #(
    parameter int WIDTH     = 32,
    parameter int BITADDR   = 13,
    parameter int REFRESH   = 1,
    parameter int REFFREQ   = 6,
    parameter int REFFRHF   = 0,
    parameter int FIFODEPTH = 4,
    parameter int BITFIFO   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               h_vld,
    output logic               h_rdy,
    input  logic               h_write,
    input  logic [BITADDR-1:0] h_wr_adr,
    input  logic [WIDTH-1:0]   h_din,
    input  logic               h_read,
    input  logic [BITADDR-1:0] h_rd_adr,
    input  logic               ready,
    output logic               refr,
    output logic               write,
    output logic [BITADDR-1:0] wr_adr,
    output logic [WIDTH-1:0]   din,
    output logic               read,
    output logic [BITADDR-1:0] rd_adr,
    output logic [BITFIFO:0]   fifo_cnt
);
    localparam int BITTMR = $clog2(REFFREQ + 2);

    typedef struct packed {
        logic               write;
        logic [BITADDR-1:0] wrAdr;
        logic [WIDTH-1:0]   din;
        logic               read;
        logic [BITADDR-1:0] rdAdr;
    } entry_t;

    entry_t             mem [FIFODEPTH];
    entry_t             head;
    entry_t             newEntry;
    logic [BITFIFO-1:0] wrPtr;
    logic [BITFIFO-1:0] rdPtr;
    logic [BITFIFO:0]   cnt;
    logic [BITTMR-1:0]  timer;
    logic [BITTMR-1:0]  period;
    logic               phase;
    logic               slot;
    logic               push;
    logic               pop;
    logic               notFull;

    assign notFull  = (cnt != (BITFIFO+1)'(FIFODEPTH));
    assign h_rdy    = notFull & rst;
    assign fifo_cnt = cnt;
    assign push     = h_vld & h_rdy & (h_write | h_read);

    // The phase bit stretches every other period by one cycle for the half-rate option.
    assign period = BITTMR'(REFFREQ) + ((REFFRHF != 0) ? BITTMR'(phase) : '0);
    assign slot   = (REFRESH != 0) & ready & (timer == (period - 1'b1));
    assign pop    = ready & (cnt != '0) & ~slot;

    assign head     = mem[rdPtr];
    assign newEntry = '{write: h_write, wrAdr: h_wr_adr, din: h_din, read: h_read, rdAdr: h_rd_adr};

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= newEntry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            cnt    <= '0;
            timer  <= '0;
            phase  <= 1'b0;
            refr   <= 1'b0;
            write  <= 1'b0;
            read   <= 1'b0;
            wr_adr <= '0;
            rd_adr <= '0;
            din    <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !push) begin
                cnt <= cnt - 1'b1;
            end

            // Timer restarts whenever the core drops ready, so the first slot after
            // ready rises is a full period away.
            if ((REFRESH == 0) || !ready || slot) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
            if (slot) begin
                phase <= ~phase;
            end

            refr  <= slot;
            write <= pop & head.write;
            read  <= pop & head.read;
            if (pop) begin
                wr_adr <= head.wrAdr;
                rd_adr <= head.rdAdr;
                din    <= head.din;
            end
        end
    end
endmodule

// File: tb/tb_algo_1r1w_a24_req_sched.sv
// Testbench for algo_1r1w_a24_req_sched: directed scenarios plus random traffic
// checked against a queue-based reference model of the scheduler.
module tb_algo_1r1w_a24_req_sched;
    localparam int WIDTH   = 32;
    localparam int BITADDR = 13;
    localparam int REFFREQ = 6;
    localparam int DEPTH   = 4;
    localparam int BITFIFO = 2;
    localparam int BW      = 3 + 2*BITADDR + WIDTH + BITFIFO + 1 + 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               h_vld = 1'b0;
    logic               h_write = 1'b0;
    logic               h_read = 1'b0;
    logic               ready = 1'b0;
    logic [BITADDR-1:0] h_wr_adr = '0;
    logic [BITADDR-1:0] h_rd_adr = '0;
    logic [WIDTH-1:0]   h_din = '0;

    logic               h_rdy, refr, write, read;
    logic [BITADDR-1:0] wr_adr, rd_adr;
    logic [WIDTH-1:0]   din;
    logic [BITFIFO:0]   fifo_cnt;

    logic               fH_rdy, fRefr, fWrite, fRead;
    logic [BITADDR-1:0] fWrAdr, fRdAdr;
    logic [WIDTH-1:0]   fDin;
    logic [BITFIFO:0]   fCnt;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    algo_1r1w_a24_req_sched dut (
        .clk(clk), .rst(rst), .h_vld(h_vld), .h_rdy(h_rdy), .h_write(h_write),
        .h_wr_adr(h_wr_adr), .h_din(h_din), .h_read(h_read), .h_rd_adr(h_rd_adr),
        .ready(ready), .refr(refr), .write(write), .wr_adr(wr_adr), .din(din),
        .read(read), .rd_adr(rd_adr), .fifo_cnt(fifo_cnt)
    );

    algo_1r1w_a24_req_sched #(.REFFRHF(1)) dutF (
        .clk(clk), .rst(rst), .h_vld(h_vld), .h_rdy(fH_rdy), .h_write(h_write),
        .h_wr_adr(h_wr_adr), .h_din(h_din), .h_read(h_read), .h_rd_adr(h_rd_adr),
        .ready(ready), .refr(fRefr), .write(fWrite), .wr_adr(fWrAdr), .din(fDin),
        .read(fRead), .rd_adr(fRdAdr), .fifo_cnt(fCnt)
    );

    wire [BW-1:0] obs0 = {refr, write, read, wr_adr, rd_adr, din, fifo_cnt, h_rdy};

    // Reference model: command queue plus a count-down to the next refresh slot.
    typedef struct packed {
        logic               w;
        logic [BITADDR-1:0] wa;
        logic [WIDTH-1:0]   d;
        logic               r;
        logic [BITADDR-1:0] ra;
    } cmd_t;

    cmd_t               mq[$];
    cmd_t               mHead, mNew;
    int                 mRemain = REFFREQ;
    logic               mRefr = 1'b0, mWrite = 1'b0, mRead = 1'b0;
    logic [BITADDR-1:0] mWrAdr = '0, mRdAdr = '0;
    logic [WIDTH-1:0]   mDin = '0;
    int                 fRemain = REFFREQ;
    logic               fPhase = 1'b0;
    logic               fRefrExp = 1'b0;
    bit                 mSlot, mAcc, fSlot;

    task automatic modelReset();
        mq.delete();
        mRemain = REFFREQ;
        mRefr = 1'b0; mWrite = 1'b0; mRead = 1'b0;
        mWrAdr = '0; mRdAdr = '0; mDin = '0;
        fRemain = REFFREQ;
        fPhase = 1'b0;
        fRefrExp = 1'b0;
    endtask

    task automatic modelStep();
        if (!rst) begin
            modelReset();
        end else begin
            mAcc  = h_vld && (h_write || h_read) && (mq.size() < DEPTH);
            mSlot = ready && (mRemain == 1);
            mRefr = mSlot;
            mWrite = 1'b0;
            mRead  = 1'b0;
            if (ready && !mSlot && mq.size() > 0) begin
                mHead  = mq.pop_front();
                mWrite = mHead.w;
                mRead  = mHead.r;
                mWrAdr = mHead.wa;
                mRdAdr = mHead.ra;
                mDin   = mHead.d;
            end
            if (mAcc) begin
                mNew = {h_write, h_wr_adr, h_din, h_read, h_rd_adr};
                mq.push_back(mNew);
            end
            mRemain = (!ready || mSlot) ? REFFREQ : mRemain - 1;

            fSlot    = ready && (fRemain == 1);
            fRefrExp = fSlot;
            if (fSlot) fPhase = ~fPhase;
            fRemain = (!ready || fSlot) ? REFFREQ + int'(fPhase) : fRemain - 1;
        end
    endtask

    function automatic logic [BW-1:0] expBundle();
        return {mRefr, mWrite, mRead, mWrAdr, mRdAdr, mDin,
                (BITFIFO+1)'(mq.size()), (rst && (mq.size() < DEPTH))};
    endfunction

    task automatic tick();
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; ready = 1'b0; h_vld = 1'b0;
        repeat (3) tick();
        vecs++;
        if (obs0 !== '0) begin errs++; $display("FAIL reset_outputs got=%h exp=0", obs0); end
        vecs++;
        if ({fRefr, fWrite, fRead, fH_rdy, fCnt} !== '0) begin
            errs++; $display("FAIL reset_outputs_frac got=%b exp=0", {fRefr, fWrite, fRead, fH_rdy, fCnt});
        end
        rst = 1'b1;
        tick();
        vecs++;
        if ({h_rdy, write, read} !== 3'b100) begin
            errs++; $display("FAIL idle_after_reset got=%b exp=100", {h_rdy, write, read});
        end
        vecs++;
        if (obs0 !== expBundle()) begin errs++; $display("FAIL idle_model got=%h exp=%h", obs0, expBundle()); end
    endtask

    task automatic test_refresh_idle();
        ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            vecs++;
            if (refr !== ((i % 6) == 0)) begin
                errs++; $display("FAIL refresh_cycle i=%0d got=%b exp=%b", i, refr, ((i % 6) == 0));
            end
            vecs++;
            if (obs0 !== expBundle()) begin errs++; $display("FAIL refresh_model got=%h exp=%h", obs0, expBundle()); end
            vecs++;
            if (fRefr !== fRefrExp) begin errs++; $display("FAIL refresh_frac got=%b exp=%b", fRefr, fRefrExp); end
        end
    endtask

    task automatic test_single();
        bit found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (refr) found = 1;
        end
        vecs++;
        if (!found) begin errs++; $display("FAIL single_wait got=no_refr exp=refr"); return; end
        h_vld = 1'b1; h_write = 1'b1; h_read = 1'b1;
        h_wr_adr = 13'h0A5; h_rd_adr = 13'h0A5; h_din = 32'hDEADBEEF;
        tick();
        h_vld = 1'b0; h_write = 1'b0; h_read = 1'b0;
        vecs++;
        if ({write, read} !== 2'b00) begin errs++; $display("FAIL single_early got=%b exp=00", {write, read}); end
        tick();
        vecs++;
        if ({write, read, wr_adr, rd_adr, din} !== {2'b11, 13'h0A5, 13'h0A5, 32'hDEADBEEF}) begin
            errs++; $display("FAIL single_issue got=%b%b %h %h %h exp=11 0a5 0a5 deadbeef", write, read, wr_adr, rd_adr, din);
        end
        vecs++;
        if (obs0 !== expBundle()) begin errs++; $display("FAIL single_model got=%h exp=%h", obs0, expBundle()); end
        tick();
        vecs++;
        if ({write, read} !== 2'b00) begin errs++; $display("FAIL single_after got=%b exp=00", {write, read}); end
    endtask

    task automatic test_frac_refresh();
        int times[$];
        int d1, d2;
        bit found = 0;
        logic [WIDTH-1:0] d;
        for (int i = 0; i < 45; i++) begin
            tick();
            vecs++;
            if (fRefr !== fRefrExp) begin errs++; $display("FAIL frac_model got=%b exp=%b", fRefr, fRefrExp); end
            if (fRefr) times.push_back(i);
        end
        vecs++;
        if (times.size() < 5) begin errs++; $display("FAIL frac_count got=%0d exp>=5", times.size()); end
        for (int k = 1; k + 1 < times.size(); k++) begin
            d1 = times[k] - times[k-1];
            d2 = times[k+1] - times[k];
            vecs++;
            if (!((d1 == 6 && d2 == 7) || (d1 == 7 && d2 == 6))) begin
                errs++; $display("FAIL frac_interval got=%0d,%0d exp=6/7 alternating", d1, d2);
            end
        end
        for (int i = 0; i < 10; i++) begin
            if (fRemain == 2) begin found = 1; break; end
            tick();
        end
        vecs++;
        if (!found) begin errs++; $display("FAIL frac_wait got=no_slot exp=slot"); return; end
        d = $urandom;
        h_vld = 1'b1; h_write = 1'b1; h_read = 1'b0; h_wr_adr = 13'h111; h_din = d;
        tick();
        h_vld = 1'b0; h_write = 1'b0;
        tick();
        vecs++;
        if ({fRefr, fWrite} !== 2'b10) begin errs++; $display("FAIL frac_slot got=%b exp=10", {fRefr, fWrite}); end
        tick();
        vecs++;
        if ({fRefr, fWrite, fRead, fWrAdr, fDin} !== {3'b010, 13'h111, d}) begin
            errs++; $display("FAIL frac_delayed got=%b%b%b %h %h exp=010 111 %h", fRefr, fWrite, fRead, fWrAdr, fDin, d);
        end
        vecs++;
        if (obs0 !== expBundle()) begin errs++; $display("FAIL frac_dut0_model got=%h exp=%h", obs0, expBundle()); end
    endtask

    task automatic test_backpressure();
        int got[$];
        repeat (3) tick();
        ready = 1'b0;
        for (int a = 1; a <= 4; a++) begin
            h_vld = 1'b1; h_write = 1'b1; h_read = 1'b1;
            h_wr_adr = BITADDR'(a); h_rd_adr = BITADDR'(a); h_din = $urandom;
            tick();
        end
        vecs++;
        if ({fifo_cnt, h_rdy} !== {3'd4, 1'b0}) begin
            errs++; $display("FAIL bp_full got=%0d,%b exp=4,0", fifo_cnt, h_rdy);
        end
        h_wr_adr = 13'd5; h_rd_adr = 13'd5;
        repeat (2) tick();
        vecs++;
        if ({fifo_cnt, write} !== {3'd4, 1'b0}) begin
            errs++; $display("FAIL bp_held got=%0d,%b exp=4,0", fifo_cnt, write);
        end
        h_vld = 1'b0; h_write = 1'b0; h_read = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 0) begin
                vecs++;
                if (h_rdy !== 1'b1) begin errs++; $display("FAIL bp_rdy_after_pop got=%b exp=1", h_rdy); end
            end
            vecs++;
            if (obs0 !== expBundle()) begin errs++; $display("FAIL bp_model got=%h exp=%h", obs0, expBundle()); end
            if (write) got.push_back(int'(wr_adr));
        end
        vecs++;
        if (got.size() != 4) begin errs++; $display("FAIL bp_issue_count got=%0d exp=4", got.size()); end
        for (int k = 0; k < got.size() && k < 4; k++) begin
            vecs++;
            if (got[k] != k + 1) begin errs++; $display("FAIL bp_order k=%0d got=%0d exp=%0d", k, got[k], k + 1); end
        end
    endtask

    task automatic test_stream();
        int issues = 0;
        ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            h_vld = 1'b1;
            h_write = (i % 2 == 0);
            h_read  = (i % 2 == 1);
            h_wr_adr = BITADDR'($urandom); h_rd_adr = BITADDR'($urandom); h_din = $urandom;
            tick();
            vecs++;
            if (obs0 !== expBundle()) begin errs++; $display("FAIL stream_model i=%0d got=%h exp=%h", i, obs0, expBundle()); end
            vecs++;
            if ((write || read) && refr) begin errs++; $display("FAIL stream_refr_overlap got=%b%b%b exp=no overlap", refr, write, read); end
            if (write || read) issues++;
        end
        h_vld = 1'b0; h_write = 1'b0; h_read = 1'b0;
        vecs++;
        if (issues < 60) begin errs++; $display("FAIL stream_rate got=%0d exp>=60", issues); end
        repeat (8) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            h_vld   = ($urandom_range(0, 9) < 7);
            h_write = $urandom_range(0, 1);
            h_read  = $urandom_range(0, 1);
            h_wr_adr = BITADDR'($urandom); h_rd_adr = BITADDR'($urandom); h_din = $urandom;
            if ($urandom_range(0, 9) == 0) ready = ~ready;
            tick();
            vecs++;
            if (obs0 !== expBundle()) begin errs++; $display("FAIL random_model i=%0d got=%h exp=%h", i, obs0, expBundle()); end
            vecs++;
            if (fRefr !== fRefrExp) begin errs++; $display("FAIL random_frac_refr i=%0d got=%b exp=%b", i, fRefr, fRefrExp); end
        end
        h_vld = 1'b0; h_write = 1'b0; h_read = 1'b0; ready = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        for (int a = 0; a < 3; a++) begin
            h_vld = 1'b1; h_write = 1'b1; h_read = 1'b1;
            h_wr_adr = BITADDR'(13'h100 + a); h_rd_adr = BITADDR'(13'h100 + a); h_din = $urandom;
            tick();
        end
        h_vld = 1'b0; h_write = 1'b0; h_read = 1'b0;
        ready = 1'b1;
        tick();
        vecs++;
        if ({write, read, fifo_cnt} !== {2'b11, 3'd2}) begin
            errs++; $display("FAIL mid_pre_reset got=%b%b,%0d exp=11,2", write, read, fifo_cnt);
        end
        #2 rst = 1'b0;
        modelReset();
        #1;
        vecs++;
        if (obs0 !== '0) begin errs++; $display("FAIL mid_async_clear got=%h exp=0", obs0); end
        #7 rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            vecs++;
            if ({write, read, fifo_cnt} !== '0) begin
                errs++; $display("FAIL mid_no_issue i=%0d got=%b%b,%0d exp=00,0", i, write, read, fifo_cnt);
            end
            vecs++;
            if (obs0 !== expBundle()) begin errs++; $display("FAIL mid_model got=%h exp=%h", obs0, expBundle()); end
        end
    endtask

    initial begin
        test_reset();
        test_refresh_idle();
        test_single();
        test_frac_refresh();
        test_backpressure();
        test_stream();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
